// File: rtl/wb_stage.sv
// Writeback stage: MEM result register, big-endian load extraction, divider holding buffer and regfile port arbitration.
// Define WB_DIV_BYPASS_EN to let an idle-slot divider result write the regfile in the same cycle it is offered.
module wb_stage #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_alu_data,
    input  logic [2:0]        mem_ld_type,
    input  logic [1:0]        mem_addr_lo,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              div_valid,
    output logic              div_ready,
    input  logic [ADDR_W-1:0] div_waddr,
    input  logic [DATA_W-1:0] div_wdata,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              buf_valid,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic              stall_req
);

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_B    = 3'd1,
        LD_BU   = 3'd2,
        LD_H    = 3'd3,
        LD_HU   = 3'd4,
        LD_W    = 3'd5
    } ld_type_e;

    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    logic              valid_q, valid_d;
    logic              wreg_q, wreg_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [2:0]        ld_type_q, ld_type_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_waddr_q, buf_waddr_d;
    logic [DATA_W-1:0] buf_wdata_q, buf_wdata_d;
    logic [3:0]        cnt_q, cnt_d;

    logic              stage_req, stage_wins, buf_drain, bypass, buf_load;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] stage_data;

    always_comb begin
        valid_d   = valid_q;
        wreg_d    = wreg_q;
        waddr_d   = waddr_q;
        alu_d     = alu_q;
        ld_type_d = ld_type_q;
        addr_lo_d = addr_lo_q;
        rdata_d   = rdata_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d   = mem_valid;
            wreg_d    = mem_wreg;
            waddr_d   = mem_waddr;
            alu_d     = mem_alu_data;
            ld_type_d = mem_ld_type;
            addr_lo_d = mem_addr_lo;
            rdata_d   = mem_rdata;
        end
    end

    // Big-endian lanes: byte 0 is the most significant byte of the word.
    always_comb begin
        byte_sel = '0;
        case (addr_lo_q)
            2'd0: byte_sel = rdata_q[31:24];
            2'd1: byte_sel = rdata_q[23:16];
            2'd2: byte_sel = rdata_q[15:8];
            2'd3: byte_sel = rdata_q[7:0];
            default: byte_sel = '0;
        endcase
        half_sel = addr_lo_q[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (ld_type_q)
            LD_B:    stage_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LD_BU:   stage_data = {{(DATA_W-8){1'b0}}, byte_sel};
            LD_H:    stage_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LD_HU:   stage_data = {{(DATA_W-16){1'b0}}, half_sel};
            LD_W:    stage_data = rdata_q;
            default: stage_data = alu_q;
        endcase
    end

    always_comb begin
        stage_req  = valid_q && wreg_q && (waddr_q != '0);
        stall_req  = buf_valid_q && (cnt_q == LIMIT);
        stage_wins = stage_req && !(stall_req && stall);
        buf_drain  = !stage_wins && buf_valid_q;
        div_ready  = !buf_valid_q;
`ifdef WB_DIV_BYPASS_EN
        bypass     = !buf_valid_q && !stage_req && div_valid;
`else
        bypass     = 1'b0;
`endif
        // Zero-destination results complete the handshake but never occupy the buffer.
        buf_load   = div_valid && !buf_valid_q && !bypass && (div_waddr != '0);

        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (stage_wins) begin
            we    = 1'b1;
            waddr = waddr_q;
            wdata = stage_data;
        end else if (buf_valid_q) begin
            we    = 1'b1;
            waddr = buf_waddr_q;
            wdata = buf_wdata_q;
        end else if (bypass && (div_waddr != '0)) begin
            we    = 1'b1;
            waddr = div_waddr;
            wdata = div_wdata;
        end

        buf_valid_d = (buf_valid_q && !buf_drain) || buf_load;
        buf_waddr_d = buf_load ? div_waddr : buf_waddr_q;
        buf_wdata_d = buf_load ? div_wdata : buf_wdata_q;

        if (!buf_valid_q || buf_drain) begin
            cnt_d = '0;
        end else if (stage_wins && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            wreg_q      <= 1'b0;
            waddr_q     <= '0;
            alu_q       <= '0;
            ld_type_q   <= '0;
            addr_lo_q   <= '0;
            rdata_q     <= '0;
            buf_valid_q <= 1'b0;
            buf_waddr_q <= '0;
            buf_wdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            wreg_q      <= wreg_d;
            waddr_q     <= waddr_d;
            alu_q       <= alu_d;
            ld_type_q   <= ld_type_d;
            addr_lo_q   <= addr_lo_d;
            rdata_q     <= rdata_d;
            buf_valid_q <= buf_valid_d;
            buf_waddr_q <= buf_waddr_d;
            buf_wdata_q <= buf_wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign buf_valid = buf_valid_q;
    assign buf_waddr = buf_waddr_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage in its default build (divider bypass disabled).
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall, flush;
    logic        mem_valid, mem_wreg;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_alu_data;
    logic [2:0]  mem_ld_type;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_rdata;
    logic        div_valid, div_ready;
    logic [4:0]  div_waddr;
    logic [31:0] div_wdata;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        buf_valid;
    logic [4:0]  buf_waddr;
    logic        stall_req;

    wb_stage #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_waddr(mem_waddr),
        .mem_alu_data(mem_alu_data), .mem_ld_type(mem_ld_type),
        .mem_addr_lo(mem_addr_lo), .mem_rdata(mem_rdata),
        .div_valid(div_valid), .div_ready(div_ready),
        .div_waddr(div_waddr), .div_wdata(div_wdata),
        .we(we), .waddr(waddr), .wdata(wdata),
        .buf_valid(buf_valid), .buf_waddr(buf_waddr), .stall_req(stall_req)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_en   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every regfile write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_en && we === 1'b1) begin
            if (sb.size() == 0) begin
                check("wr_spurious", {59'd0, waddr}, 64'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", {59'd0, waddr}, {59'd0, e.a});
                check("wr_data", {32'd0, wdata}, {32'd0, e.d});
            end
        end
    end

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_idle();
        mem_valid = 0; mem_wreg = 0; mem_waddr = 0; mem_alu_data = 0;
        mem_ld_type = 0; mem_addr_lo = 0; mem_rdata = 0;
        div_valid = 0; div_waddr = 0; div_wdata = 0;
        stall = 0; flush = 0;
    endtask

    task automatic exp_push(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic mem_drive(input logic [4:0] a, input logic [31:0] d);
        mem_valid = 1; mem_wreg = 1; mem_waddr = a; mem_alu_data = d; mem_ld_type = 0;
    endtask

    task automatic mem_wr(input logic [4:0] a, input logic [31:0] d);
        mem_drive(a, d);
        exp_push(a, d);
    endtask

    logic [2:0]  ld_t [9] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd3};
    logic [1:0]  ld_lo[9] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3};
    logic [31:0] ld_ex[9] = '{32'hFFFFFF80, 32'h000000FF, 32'h0000007F, 32'h00007F01,
                              32'h000080FF, 32'h80FF7F01, 32'h0BADF00D, 32'h00000001,
                              32'h00007F01};

    initial begin
        // Reset held two edges with a live instruction on the inputs
        drive_idle();
        rst = 0;
        mem_valid = 1; mem_wreg = 1; mem_waddr = 7; mem_alu_data = 1;
        to_pos();
        to_pos();
        to_neg();
        check("rst_we", {63'd0, we}, 64'd0);
        check("rst_div_ready", {63'd0, div_ready}, 64'd1);
        check("rst_stall_req", {63'd0, stall_req}, 64'd0);
        check("rst_buf_valid", {63'd0, buf_valid}, 64'd0);
        to_pos();
        rst = 1;
        mon_en = 1;
        mem_wr(5'd3, 32'h12345678);
        to_neg();
        check("post_rst_we", {63'd0, we}, 64'd0);

        // Sub-word loads, back to back
        for (int i = 0; i < 9; i++) begin
            to_pos();
            drive_idle();
            mem_valid = 1; mem_wreg = 1; mem_waddr = 5'(10 + i);
            mem_ld_type = ld_t[i]; mem_addr_lo = ld_lo[i];
            mem_rdata = 32'h80FF7F01; mem_alu_data = 32'h0BADF00D;
            exp_push(5'(10 + i), ld_ex[i]);
        end

        // Address zero never writes; zero-destination divider result is discarded
        to_pos();
        drive_idle();
        mem_valid = 1; mem_wreg = 1; mem_waddr = 0; mem_alu_data = 32'h99;
        to_pos();
        drive_idle();
        mem_valid = 1; mem_wreg = 0; mem_waddr = 4; mem_alu_data = 32'h44;
        to_neg();
        check("a0_we", {63'd0, we}, 64'd0);
        to_pos();
        drive_idle();
        div_valid = 1; div_waddr = 0; div_wdata = 32'h5;
        to_neg();
        check("nowreg_we", {63'd0, we}, 64'd0);
        check("a0_div_ready", {63'd0, div_ready}, 64'd1);
        to_pos();
        drive_idle();
        to_neg();
        check("a0_buf_valid", {63'd0, buf_valid}, 64'd0);
        check("a0_div_ready2", {63'd0, div_ready}, 64'd1);

        // Divider result in an idle slot goes through the buffer
        to_pos();
        div_valid = 1; div_waddr = 9; div_wdata = 32'hCAFE;
        exp_push(5'd9, 32'hCAFE);
        to_neg();
        check("idle_div_ready", {63'd0, div_ready}, 64'd1);
        check("idle_no_bypass_we", {63'd0, we}, 64'd0);
        to_pos();
        drive_idle();
        to_neg();
        check("idle_div_ready_low", {63'd0, div_ready}, 64'd0);
        check("idle_buf_valid", {63'd0, buf_valid}, 64'd1);
        check("idle_buf_waddr", {59'd0, buf_waddr}, 64'd9);
        to_pos();
        to_neg();
        check("idle_div_ready_back", {63'd0, div_ready}, 64'd1);
        check("idle_buf_empty", {63'd0, buf_valid}, 64'd0);

        // Starvation: stage writes every cycle while a divider result waits
        to_pos();
        drive_idle();
        mem_wr(5'd20, 32'h100);
        div_valid = 1; div_waddr = 21; div_wdata = 32'hD1;
        for (int i = 0; i < 3; i++) begin
            to_pos();
            drive_idle();
            mem_wr(5'(22 + i), 32'(32'h122 + i));
            to_neg();
            check("starve_buf_valid", {63'd0, buf_valid}, 64'd1);
            check("starve_req_low", {63'd0, stall_req}, 64'd0);
        end
        to_pos();
        drive_idle();
        mem_drive(5'd25, 32'h125);
        to_neg();
        check("starve_req_low4", {63'd0, stall_req}, 64'd0);
        check("starve_div_ready", {63'd0, div_ready}, 64'd0);
        to_pos();
        drive_idle();
        stall = 1;
        mem_drive(5'd26, 32'h126);
        exp_push(5'd21, 32'hD1);
        to_neg();
        check("starve_req_high", {63'd0, stall_req}, 64'd1);
        check("starve_buf_wins", {59'd0, waddr}, 64'd21);
        to_pos();
        drive_idle();
        exp_push(5'd25, 32'h125);
        to_neg();
        check("starve_req_clear", {63'd0, stall_req}, 64'd0);
        check("starve_buf_drained", {63'd0, buf_valid}, 64'd0);
        check("starve_held_we", {63'd0, we}, 64'd1);
        to_pos();
        to_neg();
        check("starve_quiet", {63'd0, we}, 64'd0);

        // Stall holds the stage for three cycles, then flush kills it
        to_pos();
        drive_idle();
        mem_wr(5'd5, 32'h55);
        for (int i = 0; i < 3; i++) begin
            to_pos();
            drive_idle();
            stall = 1;
            mem_drive(5'd6, 32'h66);
            if (i > 0) exp_push(5'd5, 32'h55);
            to_neg();
            check("stall_we", {63'd0, we}, 64'd1);
            check("stall_waddr", {59'd0, waddr}, 64'd5);
        end
        to_pos();
        drive_idle();
        flush = 1;
        mem_drive(5'd6, 32'h66);
        exp_push(5'd5, 32'h55);
        to_neg();
        check("flush_cycle_we", {63'd0, we}, 64'd1);
        to_pos();
        drive_idle();
        to_neg();
        check("flush_we", {63'd0, we}, 64'd0);

        // Second offer while the buffer is full is not taken
        to_pos();
        div_valid = 1; div_waddr = 12; div_wdata = 32'h1212;
        exp_push(5'd12, 32'h1212);
        to_pos();
        div_waddr = 13; div_wdata = 32'h1313;
        to_neg();
        check("full_div_ready", {63'd0, div_ready}, 64'd0);
        check("full_buf_waddr", {59'd0, buf_waddr}, 64'd12);
        to_pos();
        drive_idle();
        to_neg();
        check("full_no_transfer", {63'd0, buf_valid}, 64'd0);
        check("full_no_write", {63'd0, we}, 64'd0);

        // Reset mid-operation drops the buffered result
        to_pos();
        mem_wr(5'd30, 32'h300);
        div_valid = 1; div_waddr = 31; div_wdata = 32'h311;
        to_pos();
        drive_idle();
        rst = 0;
        to_neg();
        check("mid_buf_valid", {63'd0, buf_valid}, 64'd1);
        to_pos();
        rst = 1;
        to_neg();
        check("mid_rst_we", {63'd0, we}, 64'd0);
        check("mid_rst_buf", {63'd0, buf_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, div_ready}, 64'd1);
        to_pos();
        to_neg();
        check("mid_rst_quiet", {63'd0, we}, 64'd0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage: the producer side of the register file's write port (we/waddr/wdata).
- Registers MEM-stage results with stall/flush, extracts sub-word load data, and merges results from the multi-cycle divider.
- Divider results go through a one-entry holding buffer with a valid/ready handshake.
- A starvation counter forces a pipeline stall so a buffered divider result cannot wait forever.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- STARVE_LIMIT, 4, cycles a buffered divider result may wait before stall_req asserts (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (asserted when rst==0), sampled at posedge clk
- stall  in  1  hold stage register
- flush  in  1  invalidate stage register
- mem_valid  in  1  MEM slot holds an instruction
- mem_wreg  in  1  instruction writes a register
- mem_waddr  in  ADDR_W  destination register
- mem_alu_data  in  DATA_W  non-load result
- mem_ld_type  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW; 6/7 treated as 0
- mem_addr_lo  in  2  load address bits [1:0]
- mem_rdata  in  DATA_W  raw memory word
- div_valid  in  1  divider result offered
- div_ready  out  1  holding buffer empty
- div_waddr  in  ADDR_W  divider destination
- div_wdata  in  DATA_W  divider result
- we  out  1  regfile write enable
- waddr  out  ADDR_W  regfile write address
- wdata  out  DATA_W  regfile write data
- buf_valid  out  1  divider result pending (for hazard logic)
- buf_waddr  out  ADDR_W  pending destination
- stall_req  out  1  request that upstream assert stall

Behaviour:
- Reset (rst==0 at posedge): stage valid=0, buffer empty, counter=0. All outputs 0 the following cycle, except div_ready=1.
- Stage register, priority order:
  - rst==0: clear.
  - Else flush: clear valid.
  - Else stall: hold all fields.
  - Else: capture all mem_* fields.
- Latency: MEM inputs captured at edge N drive we/waddr/wdata during cycle N+1; the regfile commits them at edge N+1.
- Stage write request: stage valid & wreg & waddr!=0. A write to address 0 is never issued.
- Load extraction is big-endian; byte k (addr_lo=k) = rdata[31-8k -: 8].
  - LB/LBU: sign/zero-extend byte k.
  - LH/LHU: halfword at addr_lo[1] (0 → [31:16], 1 → [15:0]), sign/zero-extend; addr_lo[0] ignored.
  - LW: whole word.
  - Type 0: alu_data.
- Divider handshake:
  - Transfer when div_valid & div_ready at posedge; the buffer latches waddr/wdata.
  - div_ready = !buf_valid.
  - A result with div_waddr==0 is accepted and discarded (the buffer stays empty).
- Port arbiter, per cycle:
  - Stage write request and not (stall_req & stall): the stage owns the port.
  - Else if buf_valid: the buffer owns the port and empties at the clock edge.
  - Else we=0, with waddr/wdata 0.
- Starvation counter:
  - Counts cycles with buf_valid and the port lost to the stage; saturates at STARVE_LIMIT.
  - Clears when the buffer drains.
  - stall_req = buf_valid & (count==STARVE_LIMIT).
  - When stall_req and stall are both high, the buffer takes the port. The held stage instruction writes on a later cycle, and it is not lost because the stage holds under stall.
- Simultaneous events:
  - Flush while stall_req: the stage is cleared and the buffer drains at once.
  - Accept and drain never occur on the same edge; the earliest drain is the cycle after acceptance (no bypass, see below).
- Reset mid-operation: a pending buffer entry and any captured instruction are dropped. No write occurs in the cycle after reset.

Optional Feature:
- WB_DIV_BYPASS_EN defined:
  - When the buffer is empty, the stage has no write request, and div_valid is high, the divider result drives we/waddr/wdata combinationally in the same cycle.
  - The transfer completes without loading the buffer; div_ready stays 1.
- Undefined: every divider result passes through the buffer, giving at least one extra cycle.

Test Plan:
- Reset: hold rst=0 for 2 cycles with mem_valid=1 → we=0, div_ready=1, stall_req=0. After release, inputs mem_waddr=3, alu_data=0x12345678, ld_type=0 → next cycle we=1, waddr=3, wdata=0x12345678.
- Loads: mem_rdata=0x80FF7F01.
  - LB addr_lo=0 → 0xFFFFFF80.
  - LBU addr_lo=1 → 0x000000FF.
  - LB addr_lo=2 → 0x0000007F.
  - LH addr_lo=2 → 0x00007F01.
  - LHU addr_lo=0 → 0x000080FF.
- Address 0: mem_waddr=0 with wreg=1 → we=0. div_waddr=0 accepted → buf_valid stays 0.
- Divider idle slot: stage idle, div_valid for one cycle with waddr=9, wdata=0xCAFE → div_ready drops, then the next cycle we=1, waddr=9, wdata=0xCAFE, div_ready returns to 1 (bypass undefined).
- Starvation: stage writes every cycle with div result buffered, STARVE_LIMIT=4 → stall_req asserts after 4 lost cycles. With stall=1, the buffer writes and the held stage instruction writes the next cycle.
- Flush/stall: stall=1 holds waddr=5 for 3 cycles (we stays 1). flush=1 → we=0 on the next cycle. A second div_valid while buf_valid=1 → div_ready=0 and no transfer.
